// File: rtl/frame_chk_pkg.sv
// ---------------------------------------------------------------------------
// Package: frame_chk_pkg
// Shared definitions for the AXI-Stream frame checker:
//   - chk_state_e   : receive FSM states (ST_IDLE, ST_RECV)
//   - KEEP_MAX      : widest tkeep the helper functions accept
//   - keep_popcount : number of set byte enables in the low nbytes bits
//   - keep_is_tail_legal : tkeep is non-zero and contiguous from bit 0
//   - LFSR_SEED / LFSR_TAPS : back-pressure LFSR configuration
// ---------------------------------------------------------------------------
package frame_chk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } chk_state_e;

    localparam int KEEP_MAX = 64;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form (bits 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [7:0] keep_popcount(input logic [KEEP_MAX-1:0] keep,
                                                 input int nbytes);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if ((i < nbytes) && keep[i]) begin
                cnt = cnt + 8'd1;
            end
        end
        return cnt;
    endfunction

    // A mask of the form 2^k-1 (k>=1) has no bit in common with itself plus one.
    function automatic logic keep_is_tail_legal(input logic [KEEP_MAX-1:0] keep);
        return (keep != '0) && ((keep & (keep + KEEP_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_ready_lfsr.sv
// ---------------------------------------------------------------------------
// Module: axis_ready_lfsr
// Pseudo-random back-pressure generator. A 16-bit LFSR advances every cycle
// and ready is deasserted when its two low bits are both zero (~25% stall).
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   ready out registered ready, 0 during reset
// ---------------------------------------------------------------------------
module axis_ready_lfsr
    import frame_chk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic ready
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        ready_q, ready_d;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        ready_d = (lfsr_q[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

endmodule

// File: rtl/axis_frame_checker.sv
// ---------------------------------------------------------------------------
// Module: axis_frame_checker
// Receive-side sink for framed AXI-Stream. Counts valid bytes from tkeep,
// checks byte length against i_exp_length, tkeep legality and an
// incrementing-data pattern, and reports a per-frame summary plus running
// frame and error counters.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   s_axis_t{data,keep,valid,last} / s_axis_tready   input stream
//   i_exp_length               expected length, sampled on the first beat
//   o_frame_done               one-cycle pulse, summary valid in that cycle
//   o_frame_len                measured byte count of the last frame
//   o_len_err/o_keep_err/o_data_err  error flags of the last frame
//   o_frame_cnt / o_err_cnt    frames completed / frames with an error
// Configuration:
//   CHK_BACKPRESSURE_EN  when defined, tready comes from axis_ready_lfsr;
//                        otherwise tready is 1 from the cycle after reset.
// ---------------------------------------------------------------------------
module axis_frame_checker
    import frame_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [BYTE_NUM-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [LEN_WIDTH-1:0]  i_exp_length,
    output logic                  o_frame_done,
    output logic [LEN_WIDTH-1:0]  o_frame_len,
    output logic                  o_len_err,
    output logic                  o_keep_err,
    output logic                  o_data_err,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    chk_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
    logic [LEN_WIDTH-1:0]  exp_len_q, exp_len_d;
    logic [DATA_WIDTH-1:0] prev_data_q, prev_data_d;
    logic                  keep_acc_q, keep_acc_d;
    logic                  data_acc_q, data_acc_d;

    logic                  frame_done_q, frame_done_d;
    logic [LEN_WIDTH-1:0]  frame_len_q, frame_len_d;
    logic                  len_err_q, len_err_d;
    logic                  keep_err_q, keep_err_d;
    logic                  data_err_q, data_err_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    logic                  ready;
    logic                  accept;
    logic                  first_beat;
    logic [KEEP_MAX-1:0]   keep_ext;
    logic [7:0]            beat_bytes;
    logic [LEN_WIDTH:0]    cnt_sum;
    logic [LEN_WIDTH-1:0]  cnt_next;
    logic [LEN_WIDTH-1:0]  exp_now;
    logic                  keep_bad;
    logic                  data_bad;
    logic                  keep_now;
    logic                  data_now;
    logic                  len_now;

`ifdef CHK_BACKPRESSURE_EN
    axis_ready_lfsr u_ready_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .ready (ready)
    );
`else
    logic ready_q;

    // Ready comes up on the first clock edge after reset release and stays up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready = ready_q;
`endif

    assign s_axis_tready = ready;

    // Per-beat evaluation. On the first beat the accumulators restart from
    // this beat alone, so the same expressions serve single-beat frames.
    always_comb begin
        accept     = s_axis_tvalid & ready;
        first_beat = (state_q == ST_IDLE);

        keep_ext                 = '0;
        keep_ext[BYTE_NUM-1:0]   = s_axis_tkeep;
        beat_bytes               = keep_popcount(keep_ext, BYTE_NUM);

        cnt_sum  = {1'b0, (first_beat ? '0 : byte_cnt_q)}
                 + {{(LEN_WIDTH+1-8){1'b0}}, beat_bytes};
        cnt_next = cnt_sum[LEN_WIDTH] ? '1 : cnt_sum[LEN_WIDTH-1:0];

        exp_now  = first_beat ? i_exp_length : exp_len_q;

        if (s_axis_tlast) begin
            keep_bad = !keep_is_tail_legal(keep_ext);
        end else begin
            keep_bad = (s_axis_tkeep != '1);
        end

        data_bad = !first_beat && (s_axis_tdata != (prev_data_q + DATA_WIDTH'(1)));

        keep_now = keep_bad | (!first_beat & keep_acc_q);
        data_now = data_bad | (!first_beat & data_acc_q);
        len_now  = (cnt_next != exp_now);
    end

    // Next-state logic for the FSM, accumulators and registered summary.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        exp_len_d    = exp_len_q;
        prev_data_d  = prev_data_q;
        keep_acc_d   = keep_acc_q;
        data_acc_d   = data_acc_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        len_err_d    = len_err_q;
        keep_err_d   = keep_err_q;
        data_err_d   = data_err_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (accept) begin
            byte_cnt_d  = cnt_next;
            exp_len_d   = exp_now;
            prev_data_d = s_axis_tdata;
            keep_acc_d  = keep_now;
            data_acc_d  = data_now;

            if (s_axis_tlast) begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
                frame_len_d  = cnt_next;
                len_err_d    = len_now;
                keep_err_d   = keep_now;
                data_err_d   = data_now;
                frame_cnt_d  = frame_cnt_q + CNT_WIDTH'(1);
                err_cnt_d    = err_cnt_q + CNT_WIDTH'(len_now | keep_now | data_now);
            end else begin
                state_d = ST_RECV;
            end
        end
    end

    // FSM state, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            exp_len_q    <= '0;
            prev_data_q  <= '0;
            keep_acc_q   <= 1'b0;
            data_acc_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            len_err_q    <= 1'b0;
            keep_err_q   <= 1'b0;
            data_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            exp_len_q    <= exp_len_d;
            prev_data_q  <= prev_data_d;
            keep_acc_q   <= keep_acc_d;
            data_acc_q   <= data_acc_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            len_err_q    <= len_err_d;
            keep_err_q   <= keep_err_d;
            data_err_q   <= data_err_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_frame_done = frame_done_q;
    assign o_frame_len  = frame_len_q;
    assign o_len_err    = len_err_q;
    assign o_keep_err   = keep_err_q;
    assign o_data_err   = data_err_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err_cnt    = err_cnt_q;

endmodule
